seg7_scan_driver: RTL

//  Parametrised multi-digit seven-segment display driver; next generation of the single-digit hex coder.

---
 rtl/seg7_scan_driver.sv | 128 ++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multi-digit multiplexed seven-segment driver with dp, blank, blink and anti-ghost guard
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2,
    parameter int BLINK_DIV   = 64
) (
    input  logic                      fclk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   digits,
    input  logic [NUM_DIGITS-1:0]     dp_mask,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    output logic [7:0]                seg,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_tick
);

    localparam int SW = $clog2(REFRESH_DIV);
    localparam int DW = $clog2(NUM_DIGITS);
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SW-1:0] SLOT_LAST  = SW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] GUARD_END  = SW'(GUARD);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_blank;
    logic [NUM_DIGITS-1:0]   sh_blink;

    logic [SW-1:0] slot_cnt;
    logic [DW-1:0] digit_idx;
    logic [FW-1:0] frame_cnt;
    logic          blink_off;
    logic          slot_wrap;

    logic [3:0]            cur_hex;
    logic                  cur_dark;
    logic [7:0]            seg_nxt;
    logic [NUM_DIGITS-1:0] an_nxt;

    function automatic logic [6:0] enc(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            sh_digits <= '0;
            sh_dp     <= '0;
            sh_blank  <= '0;
            sh_blink  <= '0;
        end else if (load) begin
            sh_digits <= digits;
            sh_dp     <= dp_mask;
            sh_blank  <= blank_mask;
            sh_blink  <= blink_mask;
        end
    end

    assign slot_wrap  = (slot_cnt == SLOT_LAST);
    assign frame_tick = slot_wrap && (digit_idx == DIGIT_LAST);

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
            frame_cnt <= '0;
            blink_off <= 1'b0;
        end else begin
            slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
            if (slot_wrap)
                digit_idx <= (digit_idx == DIGIT_LAST) ? '0 : digit_idx + 1'b1;
            if (frame_tick) begin
                if (frame_cnt == FRAME_LAST) begin
                    frame_cnt <= '0;
                    blink_off <= ~blink_off;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    // Guard cycles at slot start keep every anode off while the cathodes settle.
    always_comb begin
        cur_hex  = sh_digits[{digit_idx, 2'b00} +: 4];
        cur_dark = sh_blank[digit_idx] | (sh_blink[digit_idx] & blink_off);
        seg_nxt  = 8'hFF;
        an_nxt   = '1;
        if (slot_cnt >= GUARD_END && !cur_dark) begin
            seg_nxt = ~{sh_dp[digit_idx], enc(cur_hex)};
            an_nxt  = ~(NUM_DIGITS'(1) << digit_idx);
        end
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= 8'hFF;
            an  <= '1;
        end else begin
            seg <= seg_nxt;
            an  <= an_nxt;
        end
    end

endmodule
